// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues word-aligned bus requests and registers MEM->WB results.
// Latency 1 cycle for ALU ops/stores, >=2 for loads; StallM asserts while the bus is not ready or a load is pending.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluoutM,
    input  logic [4:0]  rdM,
    input  logic [31:0] Mem_dataM,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic        mem_req_we,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        StallM,
    output logic [31:0] AluoutW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  rdW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic        MisalignW,
    output logic        BusErrW
);

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;
    logic        resultsrc_q, resultsrc_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    logic access;
    logic misaligned;
    logic req_vld;
    logic stall;

    assign access     = ResultSrcM | MemWriteM;
    assign misaligned = access & (AluoutM[1:0] != 2'b00);

    assign mem_req_addr  = AluoutM;
    assign mem_req_wdata = Mem_dataM;
    assign mem_req_we    = MemWriteM;
    assign mem_req_valid = req_vld & ~rst;
    assign StallM        = stall & ~rst;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        aluout_d    = AluoutM;
        rd_d        = rdM;
        regwrite_d  = RegWriteM;
        resultsrc_d = 1'b0;
        rdata_d     = '0;
        misalign_d  = 1'b0;
        buserr_d    = 1'b0;
        req_vld     = 1'b0;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    misalign_d = 1'b1;
                    regwrite_d = 1'b0;
                end else if (access) begin
                    req_vld = 1'b1;
                    if (MemWriteM) begin
                        stall = ~mem_req_ready;
                    end else begin
                        stall = 1'b1;
                        if (mem_req_ready) begin
                            state_d = WAIT_RSP;
                            tcnt_d  = 8'd0;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rdata_d     = mem_rsp_rdata;
                    resultsrc_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    if (tcnt_q == TMO_LAST) begin
                        buserr_d   = 1'b1;
                        regwrite_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A held M stage must not retire twice: stalled cycles write a bubble.
        if (stall) begin
            regwrite_d  = 1'b0;
            resultsrc_d = 1'b0;
            misalign_d  = 1'b0;
            buserr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tcnt_q      <= 8'd0;
            aluout_q    <= '0;
            rdata_q     <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            aluout_q    <= aluout_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            misalign_q  <= misalign_d;
            buserr_q    <= buserr_d;
        end
    end

    assign AluoutW    = aluout_q;
    assign ReadDataW  = rdata_q;
    assign rdW        = rd_q;
    assign RegWriteW  = regwrite_q;
    assign ResultSrcW = resultsrc_q;
    assign MisalignW  = misalign_q;
    assign BusErrW    = buserr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random transactions
// whose stall count and write-back values are predicted per transaction.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluoutM;
    logic [4:0]  rdM;
    logic [31:0] Mem_dataM;
    logic        RegWriteM;
    logic        ResultSrcM;
    logic        MemWriteM;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_we;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        StallM;
    logic [31:0] AluoutW;
    logic [31:0] ReadDataW;
    logic [4:0]  rdW;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic        MisalignW;
    logic        BusErrW;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .AluoutM      (AluoutM),
        .rdM          (rdM),
        .Mem_dataM    (Mem_dataM),
        .RegWriteM    (RegWriteM),
        .ResultSrcM   (ResultSrcM),
        .MemWriteM    (MemWriteM),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_we   (mem_req_we),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .StallM       (StallM),
        .AluoutW      (AluoutW),
        .ReadDataW    (ReadDataW),
        .rdW          (rdW),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW),
        .MisalignW    (MisalignW),
        .BusErrW      (BusErrW)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_w(input string tag, input logic [31:0] alu, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic rw, input logic rs,
                           input logic mis, input logic be);
        chk({tag, "_AluoutW"},    AluoutW,    alu);
        chk({tag, "_ReadDataW"},  ReadDataW,  rdata);
        chk({tag, "_rdW"},        rdW,        32'(rd));
        chk({tag, "_RegWriteW"},  RegWriteW,  32'(rw));
        chk({tag, "_ResultSrcW"}, ResultSrcW, 32'(rs));
        chk({tag, "_MisalignW"},  MisalignW,  32'(mis));
        chk({tag, "_BusErrW"},    BusErrW,    32'(be));
    endtask

    task automatic drive_idle();
        AluoutM    = '0;
        rdM        = '0;
        Mem_dataM  = '0;
        RegWriteM  = 1'b0;
        ResultSrcM = 1'b0;
        MemWriteM  = 1'b0;
    endtask

    // One MEM-stage instruction: bus ready after rdly request cycles, load response
    // after rspdly wait cycles (rspdly >= TO means the load times out).
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] wd, input logic rw, input logic rs, input logic mw,
                           input int rdly, input int rspdly, input logic [31:0] rdata);
        logic        acc, mis, is_store;
        int          exp_stall, exp_valid, nstall, nvalid, cyc, waitc;
        bit          hs, done;
        logic [31:0] e_rdata;
        logic        e_rw, e_rs, e_mis, e_be;

        acc      = rs | mw;
        mis      = acc && (addr[1:0] != 2'b00);
        is_store = mw;
        e_rdata  = '0;
        e_rw     = rw;
        e_rs     = 1'b0;
        e_mis    = 1'b0;
        e_be     = 1'b0;
        if (!acc || mis) begin
            exp_stall = 0;
            exp_valid = 0;
            if (mis) begin
                e_mis = 1'b1;
                e_rw  = 1'b0;
            end
        end else if (is_store) begin
            exp_stall = rdly;
            exp_valid = rdly + 1;
        end else begin
            exp_valid = rdly + 1;
            if (rspdly < TO) begin
                exp_stall = rdly + 1 + rspdly;
                e_rdata   = rdata;
                e_rs      = 1'b1;
            end else begin
                exp_stall = rdly + 1 + (TO - 1);
                e_be      = 1'b1;
                e_rw      = 1'b0;
            end
        end

        nstall = 0;
        nvalid = 0;
        cyc    = 0;
        waitc  = 0;
        hs     = 1'b0;
        done   = 1'b0;
        @(negedge clk);
        AluoutM    = addr;
        rdM        = rd;
        Mem_dataM  = wd;
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        while (!done && cyc < 200) begin
            mem_req_ready = (cyc >= rdly);
            mem_rsp_valid = hs ? (waitc == rspdly) : 1'($urandom_range(0, 1));
            mem_rsp_rdata = (hs && waitc == rspdly) ? rdata : $urandom;
            #1;
            if (mem_req_valid) begin
                nvalid++;
                chk({tag, "_req_addr"},  mem_req_addr,  addr);
                chk({tag, "_req_wdata"}, mem_req_wdata, wd);
                chk({tag, "_req_we"},    32'(mem_req_we), 32'(mw));
            end
            if (StallM) nstall++;
            else done = 1'b1;
            if (hs) waitc++;
            if (mem_req_valid && mem_req_ready) hs = 1'b1;
            cyc++;
            if (!done) @(negedge clk);
        end
        if (!done) chk({tag, "_cycle_budget"}, 32'(cyc), 32'(0));
        chk({tag, "_stall_cycles"}, 32'(nstall), 32'(exp_stall));
        chk({tag, "_req_cycles"},   32'(nvalid), 32'(exp_valid));

        @(negedge clk);
        check_w(tag, addr, e_rdata, rd, e_rw, e_rs, e_mis, e_be);
        drive_idle();
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_rdata = $urandom;
        @(negedge clk);
        chk({tag, "_flags_clear_mis"}, 32'(MisalignW), 32'(0));
        chk({tag, "_flags_clear_be"},  32'(BusErrW),   32'(0));
    endtask

    initial begin
        logic [31:0] r, addr;
        int          kind;
        logic        rs, mw;

        rst           = 1'b1;
        AluoutM       = 32'h0000_0400;
        rdM           = 5'd3;
        Mem_dataM     = 32'h1111_2222;
        RegWriteM     = 1'b1;
        ResultSrcM    = 1'b1;
        MemWriteM     = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(StallM), 32'(0));
        chk("rst_req_valid", 32'(mem_req_valid), 32'(0));
        check_w("rst", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive_idle();
        mem_rsp_valid = 1'b0;
        @(negedge clk);

        run_txn("alu",      32'h0000_1234, 5'd5,  32'h0,         1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
        run_txn("store",    32'h0000_0100, 5'd0,  32'hDEADBEEF,  1'b0, 1'b0, 1'b1, 3, 0, 32'h0);
        run_txn("load",     32'h0000_0200, 5'd7,  32'h0,         1'b1, 1'b1, 1'b0, 0, 2, 32'hCAFEF00D);
        run_txn("load_rsp0",32'h0000_0204, 5'd9,  32'h0,         1'b1, 1'b1, 1'b0, 2, 0, 32'h0BAD_F00D);
        run_txn("misalign", 32'h0000_0203, 5'd8,  32'h0,         1'b1, 1'b1, 1'b0, 0, 0, 32'h0);
        run_txn("timeout",  32'h0000_0208, 5'd10, 32'h0,         1'b1, 1'b1, 1'b0, 0, 10, 32'h1234_5678);
        run_txn("last_rsp", 32'h0000_020C, 5'd11, 32'h0,         1'b1, 1'b1, 1'b0, 1, TO - 1, 32'hA5A5_5A5A);
        run_txn("ld_st",    32'h0000_0300, 5'd12, 32'h7777_8888, 1'b1, 1'b1, 1'b1, 1, 0, 32'h0);

        // Reset taken while a load waits for its response.
        @(negedge clk);
        AluoutM       = 32'h0000_0300;
        rdM           = 5'd4;
        RegWriteM     = 1'b1;
        ResultSrcM    = 1'b1;
        MemWriteM     = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        #1;
        chk("midrst_req_stall", 32'(StallM), 32'(1));
        @(negedge clk);
        #1;
        chk("midrst_wait_stall", 32'(StallM), 32'(1));
        chk("midrst_wait_valid", 32'(mem_req_valid), 32'(0));
        rst = 1'b1;
        #1;
        chk("midrst_rst_stall", 32'(StallM), 32'(0));
        chk("midrst_rst_valid", 32'(mem_req_valid), 32'(0));
        @(negedge clk);
        check_w("midrst", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive_idle();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0000_0055;
        #1;
        chk("stray_rsp_stall", 32'(StallM), 32'(0));
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_w("stray_rsp", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            r    = $urandom;
            addr = {r[31:2], 2'b00};
            rs   = 1'b0;
            mw   = 1'b0;
            case (kind)
                0: addr = r;
                1: begin
                    addr = {r[31:2], 2'($urandom_range(1, 3))};
                    mw   = 1'($urandom_range(0, 1));
                    rs   = ~mw;
                end
                2: mw = 1'b1;
                3: rs = 1'b1;
                default: begin
                    rs = 1'b1;
                    mw = 1'b1;
                end
            endcase
            run_txn("rand", addr, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), rs, mw,
                    $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in WAIT_RSP before a load is aborted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 AluoutM  input  32  access address, or the pass-through ALU result.
REQ-005 rdM  input  5  destination register.
REQ-006 Mem_dataM  input  32  store data.
REQ-007 RegWriteM  input  1  register write enable.
REQ-008 ResultSrcM  input  1  1 = load.
REQ-009 MemWriteM  input  1  1 = store.
REQ-010 mem_req_valid  output  1  bus request valid.
REQ-011 mem_req_ready  input  1  bus accepts the request.
REQ-012 mem_req_addr  output  32  word address; always equals AluoutM.
REQ-013 mem_req_wdata  output  32  always equals Mem_dataM.
REQ-014 mem_req_we  output  1  always equals MemWriteM.
REQ-015 mem_rsp_valid  input  1  load data valid.
REQ-016 mem_rsp_rdata  input  32  load data.
REQ-017 StallM  output  1  combinational; holds EX/MEM and all earlier stages.
REQ-018 AluoutW, ReadDataW  output  32 each  registered write-back data.
REQ-019 rdW  output  5  registered.
REQ-020 RegWriteW, ResultSrcW  output  1 each  registered.
REQ-021 MisalignW, BusErrW  output  1 each  registered, one-cycle fault flags.

Function
REQ-022 Access definition: access = ResultSrcM | MemWriteM. Load and store both set is treated as a store.
REQ-023 FSM has two states, IDLE and WAIT_RSP. A separate 8-bit counter tcnt tracks time in WAIT_RSP.
REQ-024 IDLE, no access: StallM=0. Next edge, WB registers take the M values: ReadDataW=0, MisalignW=0, BusErrW=0.
REQ-025 IDLE, access with AluoutM[1:0]!=0 (misaligned):
- no bus request is issued; StallM=0;
- next edge: MisalignW=1, RegWriteW=0, ResultSrcW=0.
REQ-026 IDLE, aligned access: mem_req_valid=1 combinationally. It stays high, with stable address, data and we, until mem_req_ready=1.
REQ-027 Aligned store: completes in the mem_req_ready cycle.
- StallM=0 in that cycle;
- next edge: RegWriteW=RegWriteM, state stays IDLE.
REQ-028 Aligned load:
- StallM=1 while in IDLE;
- on the handshake edge: go to WAIT_RSP, tcnt=0, and WB registers take the bubble RegWriteW=0.
REQ-029 WAIT_RSP:
- mem_req_valid=0;
- StallM = ~mem_rsp_valid;
- tcnt increments each cycle without rsp.
REQ-030 WAIT_RSP with mem_rsp_valid=1 (this can occur in the first WAIT_RSP cycle):
- StallM=0;
- next edge: ReadDataW=mem_rsp_rdata, AluoutW=AluoutM, rdW=rdM, RegWriteW=RegWriteM, ResultSrcW=1;
- state returns to IDLE.
REQ-031 WAIT_RSP, no rsp, tcnt==TIMEOUT-1: StallM=0. Next edge: BusErrW=1, RegWriteW=0, state returns to IDLE. A later stray response is ignored.
REQ-032 Any cycle with StallM=1: the next edge writes a bubble into WB (RegWriteW=0, MisalignW=0, BusErrW=0). Other W fields are don't-care.
REQ-033 mem_rsp_valid in IDLE is ignored. mem_req_ready in WAIT_RSP is ignored.
REQ-034 Latency:
- non-access: 1 cycle to W;
- store with ready high: 1 cycle;
- load: at least 2 cycles (request, then response).
REQ-035 tcnt never wraps; it is cleared on every entry to WAIT_RSP.

Reset
REQ-036 Under rst=1 at an edge, every output register, the state and tcnt take these values:
- state=IDLE, tcnt=0;
- AluoutW=0, ReadDataW=0, rdW=0;
- RegWriteW=0, ResultSrcW=0, MisalignW=0, BusErrW=0.
REQ-037 Reset taken mid-load (in WAIT_RSP) returns to IDLE. The outstanding response is dropped per REQ-033.
REQ-038 While rst=1, mem_req_valid=0 and StallM=0.

Verification
REQ-039 ALU op: AluoutM=0x1234, rdM=5, RegWriteM=1, no access -> next cycle AluoutW=0x1234, rdW=5, RegWriteW=1, StallM never 1.
REQ-040 Store, addr 0x100, data 0xDEADBEEF, ready low 3 cycles then high:
- valid high 4 cycles with stable addr/data/we=1;
- StallM=1 for 3 cycles, 0 in the 4th.
REQ-041 Load, addr 0x200, ready=1 immediately, rsp 2 cycles later with 0xCAFEF00D, rdM=7 -> StallM=1 for 3 cycles; after completion ReadDataW=0xCAFEF00D, rdW=7, RegWriteW=1.
REQ-042 Load at addr 0x203 -> no mem_req_valid; next cycle MisalignW=1, RegWriteW=0.
REQ-043 Load, TIMEOUT=4, no response -> StallM=1 for 4 cycles (request cycle plus 3 WAIT_RSP cycles), then 0; BusErrW=1 one cycle; a late rsp is ignored.
REQ-044 rst asserted in WAIT_RSP -> next cycle IDLE, all W outputs 0; a response arriving afterwards changes no output.
